// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the sequencer, its controller and the counter.
// slave: sequencer side; master: controller plus counter feedback side.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             sel;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rounds;

  modport master (
    output start, stop, sel, limit, cnt_q,
    input  cnt_clr, cnt_en, busy, done, rounds
  );

  modport slave (
    input  start, stop, sel, limit, cnt_q,
    output cnt_clr, cnt_en, busy, done, rounds
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Counter sequencer: clear, enable for limit cycles, flag done, reload.
// Ports: clk, reset (async, active-high), bus (slave: start/stop/sel/limit/cnt_q in; cnt_clr/cnt_en/busy/done/rounds out).
module counter_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  counter_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] rounds_q, rounds_d;
  logic [WIDTH-1:0] lim_m1;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign lim_m1 = lim_q - WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    lim_d    = lim_q;
    rounds_d = rounds_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = CLEAR;
          lim_d    = bus.limit;
          rounds_d = '0;
        end
      end
      CLEAR: begin
        if (bus.stop)
          state_d = IDLE;
        else if (lim_q == '0)
          state_d = DONE;
        else
          state_d = RUN;
      end
      RUN: begin
        if (bus.stop)
          state_d = IDLE;
        else if (bus.cnt_q == lim_m1)
          state_d = DONE;
      end
      DONE: begin
        if (bus.stop || !bus.sel)
          state_d = IDLE;
        else
          state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
    // Count the run as it enters DONE so rounds agrees with the done pulse.
    if (state_d == DONE)
      rounds_d = rounds_q + WIDTH'(1);
  end

  // Outputs decoded from the next state so they line up with their state.
  always_comb begin
    clr_d  = 1'b0;
    en_d   = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (1'b1)
      (state_d == CLEAR): clr_d  = 1'b1;
      (state_d == RUN):   en_d   = 1'b1;
      (state_d == DONE):  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lim_q    <= '0;
      rounds_q <= '0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lim_q    <= lim_d;
      rounds_q <= rounds_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.cnt_clr = clr_q;
  assign bus.cnt_en  = en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rounds  = rounds_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with a counter model attached.
// Expected per-cycle outputs come from a run-level plan built from the rules.
module tb_counter_seq_ctrl;
  typedef logic [11:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt;
  vec_t       expq[$];
  bit         selq[$];
  int         checks = 0;
  int         passed = 0;
  int         model_r = 0;

  counter_seq_ctrl_if #(.WIDTH(8)) bus();

  counter_seq_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (bus.cnt_clr)
      cnt <= '0;
    else if (bus.cnt_en)
      cnt <= cnt + 8'd1;
  end

  assign bus.cnt_q = cnt;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic vec_t mk(input bit c, input bit e, input bit b,
                              input bit d, input int r);
    logic [7:0] rr;
    rr = r[7:0];
    return {c, e, b, d, rr};
  endfunction

  function automatic vec_t obs();
    return {bus.cnt_clr, bus.cnt_en, bus.busy, bus.done, bus.rounds};
  endfunction

  // Each run: 1 clear cycle, L enable cycles, 1 done cycle.
  // A stop seen in cycle k leaves idle next cycle with that cycle's rounds.
  task automatic plan(input int L, input int reloads, input int stop_at);
    int   r;
    vec_t last;
    r = 0;
    expq.delete();
    selq.delete();
    for (int k = 0; k <= reloads; k++) begin
      expq.push_back(mk(1, 0, 1, 0, r));
      selq.push_back(1'($urandom));
      for (int j = 0; j < L; j++) begin
        expq.push_back(mk(0, 1, 1, 0, r));
        selq.push_back(1'($urandom));
      end
      r = (r + 1) % 256;
      expq.push_back(mk(0, 0, 1, 1, r));
      selq.push_back(k < reloads);
    end
    while (stop_at >= 0 && expq.size() > stop_at + 1) begin
      void'(expq.pop_back());
      void'(selq.pop_back());
    end
    last = expq[expq.size()-1];
    model_r = int'(last[7:0]);
    expq.push_back(mk(0, 0, 0, 0, model_r));
    selq.push_back(1'b0);
  endtask

  task automatic launch(input int L);
    bus.limit = 8'(L);
    bus.stop  = 1'b0;
    bus.sel   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.limit = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0, 0))
      $display("FAIL reset_hold: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
    else
      passed++;
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0, 0))
      $display("FAIL reset_idle: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
    else
      passed++;
    model_r = 0;
  endtask

  task automatic test_oneshot();
    plan(5, 0, -1);
    launch(5);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL oneshot[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    checks++;
    if (cnt !== 8'd5)
      $display("FAIL oneshot_cnt: got %0d want 5", cnt);
    else
      passed++;
  endtask

  task automatic test_reload();
    plan(3, 4, -1);
    launch(3);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL reload[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_zero();
    plan(0, 0, -1);
    launch(0);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL zero[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_stop();
    plan(8, 0, 5);
    launch(8);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL stop[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      bus.stop  = (i == 5);
      @(posedge clk);
      #1;
      bus.stop = 1'b0;
    end
    bus.start = 1'b0;
    checks++;
    if (cnt !== 8'd5)
      $display("FAIL stop_cnt: got %0d want 5", cnt);
    else
      passed++;
  endtask

  task automatic test_async_reset();
    launch(8);
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== mk(0, 0, 0, 0, 0))
      $display("FAIL async_rst: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
    else
      passed++;
    @(negedge clk);
    rst = 1'b0;
    model_r = 0;
    @(posedge clk);
    #1;
    plan(3, 0, -1);
    launch(3);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL after_rst[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_ignore();
    int r0;
    r0 = model_r;
    bus.limit = 8'd7;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (obs() !== mk(0, 0, 0, 0, r0))
      $display("FAIL start_stop: got %h want %h", obs(), mk(0, 0, 0, 0, r0));
    else
      passed++;
    plan(4, 0, -1);
    launch(4);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL ignore[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'b1;
      bus.limit = 8'd9;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_wrap();
    plan(0, 256, -1);
    launch(0);
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obs() !== expq[i])
        $display("FAIL wrap[%0d]: got %h want %h", i, obs(), expq[i]);
      else
        passed++;
      if (i == expq.size() - 1) break;
      bus.sel   = selq[i];
      bus.start = 1'($urandom);
      bus.limit = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_random();
    int L, rl, len, sa;
    for (int t = 0; t < 25; t++) begin
      L   = int'($urandom_range(0, 9));
      rl  = int'($urandom_range(0, 3));
      len = (rl + 1) * (L + 2);
      sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      plan(L, rl, sa);
      launch(L);
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (obs() !== expq[i])
          $display("FAIL rand%0d[%0d]: got %h want %h", t, i, obs(), expq[i]);
        else
          passed++;
        if (i == expq.size() - 1) break;
        bus.sel   = selq[i];
        bus.start = 1'($urandom);
        bus.limit = 8'($urandom);
        bus.stop  = (i == sa);
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
      end
      bus.start = 1'b0;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.sel   = 1'b0;
    bus.limit = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_zero();
    test_stop();
    test_async_reset();
    test_ignore();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
